// File: rtl/shift_pkg.sv
// Shared definitions for the parallel-to-serial transmit stage and the
// downstream serial-input shift register that it feeds.
package shift_pkg;

    // Serializer control states: the shifter is either empty or holds a word.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit order. The downstream shift register interprets these values the same way.
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_hold_buffer.sv
// One-entry valid/ready holding register for a word and its bit order.
// The shifter drains it through pop_i when it starts a new word.
module shift_hold_buffer
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] push_data_i,
    input  logic         push_dir_i,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic         pop_i,
    output logic         hold_valid_o,
    output logic [N-1:0] hold_data_o,
    output logic         hold_dir_o
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q,  data_d;
    logic         dir_q,   dir_d;

    // The buffer accepts a word only while empty, so the flow control depends on the stored flag alone.
    assign push_ready_o = !valid_q;
    assign hold_valid_o = valid_q;
    assign hold_data_o  = data_q;
    assign hold_dir_o   = dir_q;

    // Next-state logic: a push fills the empty entry and a pop empties the full one.
    // Both cannot happen on the same edge because they require opposite valid states.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        dir_d   = dir_q;
        if (push_valid_i && push_ready_o) begin
            valid_d = 1'b1;
            data_d  = push_data_i;
            dir_d   = push_dir_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers. Reset discards any buffered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmit stage. Words enter a one-entry hold buffer
// and are then shifted out one bit per enabled clock, MSB-first or LSB-first.
// On the last bit, the shifter reloads directly from the hold buffer so that
// back-to-back words have no idle slot between them.
module shift_serializer
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         direction,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         enable,
    output logic         serial_out,
    output logic         bit_valid,
    output logic         bit_last,
    output logic         busy
);

    localparam int                CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [N-1:0]      shreg_q, shreg_d;
    logic              dir_q,   dir_d;

    logic              hold_valid;
    logic [N-1:0]      hold_data;
    logic              hold_dir;
    logic              hold_pop;

    shift_hold_buffer #(
        .N(N)
    ) u_hold (
        .clk          (clk),
        .reset        (reset),
        .push_data_i  (data_in),
        .push_dir_i   (direction),
        .push_valid_i (load_valid),
        .push_ready_o (load_ready),
        .pop_i        (hold_pop),
        .hold_valid_o (hold_valid),
        .hold_data_o  (hold_data),
        .hold_dir_o   (hold_dir)
    );

    // Next-state logic: start a word from the hold buffer, then shift it out.
    // On the last bit, either chain into the buffered word or return to idle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        dir_d    = dir_q;
        hold_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_valid) begin
                    shreg_d  = hold_data;
                    dir_d    = hold_dir;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                    hold_pop = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    if (cnt_q == LAST_CNT) begin
                        if (hold_valid) begin
                            shreg_d  = hold_data;
                            dir_d    = hold_dir;
                            cnt_d    = '0;
                            hold_pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (dir_q == DIR_LSB_FIRST) begin
                            shreg_d = {1'b0, shreg_q[N-1:1]};
                        end else begin
                            shreg_d = {shreg_q[N-2:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serial outputs: the current bit is taken from whichever end of the shifter faces downstream.
    // All outputs are forced low while the shifter is empty.
    always_comb begin
        serial_out = 1'b0;
        bit_valid  = 1'b0;
        bit_last   = 1'b0;
        if (state_q == ST_SHIFT) begin
            bit_valid  = 1'b1;
            bit_last   = (cnt_q == LAST_CNT);
            serial_out = (dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[N-1];
        end
    end

    assign busy = (state_q == ST_SHIFT) || hold_valid;

    // State, counter and shifter registers. Reset discards any partially sent word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Testbench for shift_serializer with N=8: directed scenarios plus a randomized
// run checked against a word-level model of the transmitted bit stream.
module tb_shift_serializer;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] data_in;
    logic         direction;
    logic         load_valid;
    logic         load_ready;
    logic         enable;
    logic         serial_out;
    logic         bit_valid;
    logic         bit_last;
    logic         busy;

    int tests;
    int failed;

    // The expected stream is built from accepted words. The observed stream is
    // built from bits the DUT presented on consume edges.
    logic expQ[$];
    logic expLastQ[$];
    logic obsQ[$];
    logic obsLastQ[$];

    shift_serializer #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .direction  (direction),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .enable     (enable),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .bit_last   (bit_last),
        .busy       (busy)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of a word, in transmit order for the given direction
    function automatic logic expBit(input logic [N-1:0] w, input logic d, input int i);
        return d ? w[i] : w[N-1-i];
    endfunction

    // Advance one clock. Observed and expected streams are recorded before the edge,
    // and outputs are sampled 1 unit after it.
    task automatic tick();
        if (!reset && bit_valid && enable) begin
            obsQ.push_back(serial_out);
            obsLastQ.push_back(bit_last);
        end
        if (!reset && load_valid && load_ready) begin
            for (int i = 0; i < N; i++) begin
                expQ.push_back(expBit(data_in, direction, i));
                expLastQ.push_back(i == N - 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clearStreams();
        expQ.delete();
        expLastQ.delete();
        obsQ.delete();
        obsLastQ.delete();
    endtask

    // Offer a word until it is accepted, with a bounded wait. This task always performs
    // exactly one accepting edge. It returns with load_valid low and data_in scrambled.
    task automatic drive_word(input logic [N-1:0] w, input logic d);
        int waited;
        waited     = 0;
        load_valid = 1'b1;
        data_in    = w;
        direction  = d;
        while (!load_ready && waited < 50) begin
            tick();
            waited++;
        end
        tests++;
        if (!load_ready) begin
            failed++;
            $display("[TB] FAIL drive_word_timeout: load_ready got %b expected 1", load_ready);
        end
        tick();
        load_valid = 1'b0;
        data_in    = N'($urandom);
        direction  = 1'($urandom);
    endtask

    // Run with enable high until the DUT goes idle. Returns 1 if idle within the bound.
    task automatic drain(output logic ok);
        int c;
        c = 0;
        enable = 1'b1;
        while (busy && c < 100) begin
            tick();
            c++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'h55;
        direction  = 1'b0;
        enable     = 1'b1;
        tick();
        tick();
        load_valid = 1'b0;
        reset      = 1'b0;
        tests++;
        if ({load_ready, busy, bit_valid, bit_last, serial_out} !== 5'b10000) begin
            failed++;
            $display("[TB] FAIL reset_outputs: got rdy/busy/vld/last/out=%b expected 10000",
                     {load_ready, busy, bit_valid, bit_last, serial_out});
        end
        tick();
        tick();
        tests++;
        if (busy !== 1'b0 || bit_valid !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_priority: got busy=%b bit_valid=%b expected 0 0", busy, bit_valid);
        end
    endtask

    // Send one word with enable held high and check latency, bit order, and bit_last.
    task automatic test_single(input logic [N-1:0] w, input logic d);
        logic ok;
        enable = 1'b1;
        drive_word(w, d);
        tests++;
        if (bit_valid !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b0) begin
            failed++;
            $display("[TB] FAIL single_latency: got vld=%b busy=%b rdy=%b expected 0 1 0",
                     bit_valid, busy, load_ready);
        end
        tick();
        for (int i = 0; i < N; i++) begin
            tests++;
            if (bit_valid !== 1'b1 || serial_out !== expBit(w, d, i) || bit_last !== (i == N - 1)) begin
                failed++;
                $display("[TB] FAIL single_bit%0d word=%h dir=%b: got vld=%b out=%b last=%b expected 1 %b %b",
                         i, w, d, bit_valid, serial_out, bit_last, expBit(w, d, i), (i == N - 1));
            end
            tick();
        end
        tests++;
        if (bit_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            failed++;
            $display("[TB] FAIL single_idle: got vld=%b busy=%b rdy=%b expected 0 0 1",
                     bit_valid, busy, load_ready);
        end
        drain(ok);
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] pattern;
        logic ok;
        pattern = 16'b0000_1111_0000_1111;
        enable  = 1'b1;
        drive_word(8'h0F, 1'b0);
        tick();
        for (int c = 0; c < 2 * N; c++) begin
            tests++;
            if (bit_valid !== 1'b1 || serial_out !== pattern[2*N-1-c]) begin
                failed++;
                $display("[TB] FAIL b2b_bit%0d: got vld=%b out=%b expected 1 %b",
                         c, bit_valid, serial_out, pattern[2*N-1-c]);
            end
            if (c >= 3) begin
                tests++;
                if (load_ready !== (c >= N)) begin
                    failed++;
                    $display("[TB] FAIL b2b_ready_c%0d: got %b expected %b", c, load_ready, (c >= N));
                end
            end
            if (c == 2) begin
                tests++;
                if (load_ready !== 1'b1) begin
                    failed++;
                    $display("[TB] FAIL b2b_ready_accept: got %b expected 1", load_ready);
                end
                drive_word(8'hF0, 1'b1);
            end else begin
                tick();
            end
        end
        tests++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL b2b_end: got vld=%b busy=%b expected 0 0", bit_valid, busy);
        end
        drain(ok);
    endtask

    task automatic test_enable_stall();
        logic ok;
        enable = 1'b1;
        drive_word(8'hA5, 1'b0);
        tick();
        for (int i = 0; i < N; i++) begin
            if (i == 3) begin
                enable = 1'b0;
                repeat (3) begin
                    tick();
                    tests++;
                    if (bit_valid !== 1'b1 || serial_out !== expBit(8'hA5, 1'b0, 3) || bit_last !== 1'b0) begin
                        failed++;
                        $display("[TB] FAIL stall_hold: got vld=%b out=%b last=%b expected 1 %b 0",
                                 bit_valid, serial_out, bit_last, expBit(8'hA5, 1'b0, 3));
                    end
                end
                enable = 1'b1;
            end
            tests++;
            if (bit_valid !== 1'b1 || serial_out !== expBit(8'hA5, 1'b0, i) || bit_last !== (i == N - 1)) begin
                failed++;
                $display("[TB] FAIL stall_bit%0d: got vld=%b out=%b last=%b expected 1 %b %b",
                         i, bit_valid, serial_out, bit_last, expBit(8'hA5, 1'b0, i), (i == N - 1));
            end
            tick();
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL stall_end: busy got %b expected 0", busy);
        end
        drain(ok);
    endtask

    task automatic test_hold_full();
        logic exp[$];
        logic ok;
        clearStreams();
        enable = 1'b1;
        for (int i = 0; i < N; i++) exp.push_back(expBit(8'h3C, 1'b0, i));
        for (int i = 0; i < N; i++) exp.push_back(expBit(8'h96, 1'b1, i));
        drive_word(8'h3C, 1'b0);
        tick();
        drive_word(8'h96, 1'b1);
        load_valid = 1'b1;
        data_in    = 8'hFF;
        direction  = 1'b0;
        repeat (3) begin
            tests++;
            if (load_ready !== 1'b0) begin
                failed++;
                $display("[TB] FAIL holdfull_ready: got %b expected 0", load_ready);
            end
            tick();
        end
        load_valid = 1'b0;
        drain(ok);
        tests++;
        if (!ok || obsQ.size() != exp.size()) begin
            failed++;
            $display("[TB] FAIL holdfull_len: got %0d bits idle=%b expected %0d bits idle=1",
                     obsQ.size(), ok, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                tests++;
                if (obsQ[i] !== exp[i]) begin
                    failed++;
                    $display("[TB] FAIL holdfull_bit%0d: got %b expected %b", i, obsQ[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lastSeen;
        int activity;
        lastSeen = 0;
        activity = 0;
        enable   = 1'b1;
        drive_word(8'h3C, 1'b0);
        tick();
        drive_word(8'h81, 1'b1);
        repeat (3) begin
            if (bit_last) lastSeen++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({load_ready, busy, bit_valid, bit_last, serial_out} !== 5'b10000) begin
            failed++;
            $display("[TB] FAIL midreset_outputs: got rdy/busy/vld/last/out=%b expected 10000",
                     {load_ready, busy, bit_valid, bit_last, serial_out});
        end
        repeat (20) begin
            if (bit_valid || bit_last || busy) activity++;
            if (bit_last) lastSeen++;
            tick();
        end
        tests++;
        if (activity != 0 || lastSeen != 0) begin
            failed++;
            $display("[TB] FAIL midreset_discard: got activity=%0d last=%0d expected 0 0", activity, lastSeen);
        end
    endtask

    // Random handshakes and enable gaps compared against the word-level stream model
    task automatic test_random();
        logic ok;
        clearStreams();
        for (int c = 0; c < 600; c++) begin
            load_valid = ($urandom_range(0, 2) != 0);
            data_in    = N'($urandom);
            direction  = 1'($urandom);
            enable     = ($urandom_range(0, 3) != 0);
            tick();
        end
        load_valid = 1'b0;
        drain(ok);
        tests++;
        if (!ok || obsQ.size() != expQ.size()) begin
            failed++;
            $display("[TB] FAIL random_len: got %0d bits idle=%b expected %0d bits idle=1",
                     obsQ.size(), ok, expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                tests++;
                if (obsQ[i] !== expQ[i] || obsLastQ[i] !== expLastQ[i]) begin
                    failed++;
                    $display("[TB] FAIL random_bit%0d: got out=%b last=%b expected %b %b",
                             i, obsQ[i], obsLastQ[i], expQ[i], expLastQ[i]);
                end
            end
        end
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        direction  = 1'b0;
        enable     = 1'b0;
        test_reset();
        test_single(8'hA5, 1'b0);
        test_single(8'hC1, 1'b1);
        test_back_to_back();
        test_enable_stall();
        test_hold_full();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-in, serial-out transmit stage that sits directly upstream of the serial-input shift register and drives its `I` and `enable` inputs. It accepts N-bit words over a valid/ready handshake, buffers one word while shifting the current one, and emits bits MSB-first or LSB-first at one bit per enabled clock. The hold buffer allows back-to-back words with no idle bit slot between them.

## Interface
- `N`: default 8. Word width; must be ≥ 2.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `data_in`: input, N bits. Word to transmit.
- `direction`: input, 1 bit. 0 = MSB first, 1 = LSB first. Sampled together with `data_in`.
- `load_valid`: input, 1 bit. `data_in`/`direction` valid.
- `load_ready`: output, 1 bit. Hold buffer empty; a word is accepted on an edge where `load_valid && load_ready`.
- `enable`: input, 1 bit. Downstream advance; the current bit is consumed on an edge where `bit_valid && enable`.
- `serial_out`: output, 1 bit. Current bit; feeds downstream `I`.
- `bit_valid`: output, 1 bit. `serial_out` carries a data bit.
- `bit_last`: output, 1 bit. Current bit is bit N-1 of the word.
- `busy`: output, 1 bit. Shifter or hold buffer occupied.

## Operation
- States: IDLE (shifter empty) and SHIFT (word in shifter).
- Hold buffer: `hold_data[N-1:0]`, `hold_dir`, and `hold_valid`. `load_ready = !hold_valid`, driven combinationally.
- Accept: on a handshake edge, latch `data_in` and `direction` and set `hold_valid`.
- IDLE with `hold_valid`, on the next edge:
  - move hold into shifter (`shreg`, `dir_q`);
  - set `cnt = 0`, `state = SHIFT`, `hold_valid = 0`.
- `serial_out` in SHIFT:
  - `dir_q=0`: `serial_out = shreg[N-1]`, and each consume shifts left.
  - `dir_q=1`: `serial_out = shreg[0]`, and each consume shifts right.
- Outputs in SHIFT: `bit_valid = 1` and `bit_last = (cnt == N-1)`.
- Outputs in IDLE: `serial_out`, `bit_valid`, and `bit_last` are 0.
- Consume edge, not last bit: shift and `cnt++`.
- Consume edge, last bit:
  - `hold_valid=1`: reload from hold on the same edge and stay in SHIFT. No gap, and `load_ready` rises next cycle.
  - `hold_valid=0`: go to IDLE.
- `enable=0` in SHIFT: `shreg`, `cnt`, and `serial_out` are held, and `bit_valid` stays 1.
- `busy = (state==SHIFT) || hold_valid`.
- Counter width is `$clog2(N)`. `cnt` never exceeds N-1.

## Timing
- Reset (any state, including mid-word): next cycle `state=IDLE`, `hold_valid=0`, `load_ready=1`, and `serial_out=bit_valid=bit_last=busy=0`. The partial word and the buffered word are discarded.
- Reset has priority over a handshake on the same edge; that word is not accepted.
- Latency: accept at edge k → hold at k → first bit on `serial_out` after edge k+1 (two edges from handshake to bit 0).
- Throughput: one bit per enabled cycle, and N enabled cycles per word.
- Sustained back-to-back: new words are accepted while shifting with `load_ready=1`, and output bits stay contiguous.
- Handshake while `hold_valid=1`: `load_ready=0`, so no accept, and hold contents are unchanged.
- A handshake edge and a transfer or reload edge cannot coincide, because a handshake requires `hold_valid=0` and a transfer requires `hold_valid=1`.
- `direction` changes during a word have no effect on that word.

## Structure
- Shared package `shift_pkg`:
  - state enum `{ST_IDLE, ST_SHIFT}`;
  - constants `DIR_MSB_FIRST = 1'b0` and `DIR_LSB_FIRST = 1'b1`.
  - The downstream shift register uses the same direction constants.
- One natural sub-module, `shift_hold_buffer`: a one-entry valid/ready holding register with data plus direction, exposing `pop` to the shifter.
- The FSM, counter, and shift register stay in `shift_serializer`.

## Test plan
All scenarios use N=8.
- Reset, load `0xA5` with `direction=0`, `enable=1` constant → from the 2nd edge after accept, `serial_out = 1,0,1,0,0,1,0,1`; `bit_last` high on the 8th bit; then IDLE with `busy=0`.
- Load `0xC1` with `direction=1` → `serial_out = 1,0,0,0,0,0,1,1`.
- Load `0x0F` (dir 0), then `0xF0` (dir 1) during bit 2 → 16 contiguous `bit_valid` cycles: `0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1`. `load_ready=0` from the second accept until the reload edge.
- `0xA5` with `enable` dropped for 3 cycles after bit 3 consumed → `serial_out` held at bit 3 (0), `bit_valid=1`, and the remaining bits resume unchanged.
- Assert `load_valid` with `0xFF` while hold is full → not accepted; the buffered word is transmitted intact.
- Reset after 4 bits of `0x3C` with a word in hold → next cycle all outputs are at reset values, `load_ready=1`, `bit_last` is never asserted, and the buffered word is never transmitted.
